// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame size and the baud divider
// helpers that both the receiver and the emitter derive their timing from.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  // Clock cycles per bit, rounded down.
  function automatic int calc_div(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

  // Width of a down-counter that must hold DIV-1.
  function automatic int calc_cnt_w(input int clk_freq_hz, input int baud_rate);
    return $clog2(calc_div(clk_freq_hz, baud_rate));
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// IO-bus side of the UART receiver: head-of-FIFO byte with valid/pop handshake
// plus sticky error flags and their clear pulse.
interface uart_receiver_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_pop;
  logic                 i_clr_err;
  logic                 o_overrun;
  logic                 o_frame_err;
  logic                 o_parity_err;

  // Firmware / bus side.
  modport master (
    input  o_data, o_valid, o_overrun, o_frame_err, o_parity_err,
    output i_pop, i_clr_err
  );

  // Receiver side.
  modport slave (
    output o_data, o_valid, o_overrun, o_frame_err, o_parity_err,
    input  i_pop, i_clr_err
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO. Decides itself whether an incoming byte
// must be dropped (full with no simultaneous pop) and reports it on drop.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
    $error("uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en;
  logic             rd_en;

  // Pointers carry a wrap bit: equal means empty, differing only in the MSB means full.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    rd_en    = pop & ~empty;
    wr_en    = push & (~full | rd_en);
    drop     = push & full & ~rd_en;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  // Stale storage is masked so the bus sees zero whenever nothing is queued.
  assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 2-FF synchronizer, baud counter, deframing FSM and sticky flags.
// Even parity is expected when UART_RX_PARITY_EN is defined; otherwise frames are 8N1.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 1_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            rxd,
  uart_receiver_if.slave  bus
);

  localparam int DIV   = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W = calc_cnt_w(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BIT_W = $clog2(DATA_BITS);

  if (DIV < 4) begin : g_div_check
    $error("uart_receiver: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
  end

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = RX_IDLE;
  localparam logic [2:0] ST_START  = RX_START;
  localparam logic [2:0] ST_DATA   = RX_DATA;
  localparam logic [2:0] ST_STOP   = RX_STOP;
  localparam logic [2:0] ST_BREAK  = RX_BREAK;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = RX_PARITY;
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

  logic                 sync1_q, sync1_d;
  logic                 rxs_q, rxs_d;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  logic                 cnt_end;
  logic                 push;
  logic                 frame_set;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_drop;
  logic [DATA_BITS-1:0] fifo_dout;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
  logic                 parity_set;
`endif

  always_comb begin
    sync1_d     = rxd;
    rxs_d       = sync1_q;
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_set   = 1'b0;
    cnt_end     = (cnt_q == '0);
    cnt_d       = cnt_end ? cnt_q : cnt_q - CNT_W'(1);
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    parity_set  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          cnt_d   = CNT_HALF;
          state_d = ST_START;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (cnt_end) begin
          if (rxs_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d     = CNT_FULL;
            bit_idx_d = '0;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cnt_end) begin
          shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
          cnt_d     = CNT_FULL;
          bit_idx_d = bit_idx_q + BIT_W'(1);
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_AFTER_DATA;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_end) begin
          par_bad_d = rxs_q ^ (^shift_q);
          cnt_d     = CNT_FULL;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_end) begin
          if (!rxs_q) begin
            frame_set = 1'b1;
            state_d   = ST_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            parity_set = 1'b1;
            state_d    = ST_IDLE;
`endif
          end else begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      // A line held low after a bad stop bit must not look like new start bits.
      ST_BREAK: begin
        if (rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new error event outranks a clear issued in the same cycle.
    overrun_d   = (overrun_q & ~bus.i_clr_err) | fifo_drop;
    frame_err_d = (frame_err_q & ~bus.i_clr_err) | frame_set;
`ifdef UART_RX_PARITY_EN
    parity_err_d = (parity_err_q & ~bus.i_clr_err) | parity_set;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (bus.i_pop),
    .din    (shift_q),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .drop   (fifo_drop)
  );

  // Drops can only happen against a full buffer.
  assert property (@(posedge clk) disable iff (!resetn) fifo_drop |-> fifo_full);

  assign bus.o_data      = fifo_dout;
  assign bus.o_valid     = ~fifo_empty;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.o_parity_err = parity_err_q;
`else
  assign bus.o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboarded bench for uart_receiver at DIV=10; bytes expected to arrive are
// queued as they are sent and compared as they are popped from the DUT.
module tb_uart_receiver;

  localparam int DIV = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Cycle (relative to the start-bit pin edge) in which the stop bit is sampled.
  localparam int STOP_CYC = (NBITS - 1) * DIV + DIV / 2 + 2;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic rxd    = 1'b1;

  uart_receiver_if bus ();

  uart_receiver #(
    .CLK_FREQ_HZ (10_000_000),
    .BAUD_RATE   (1_000_000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .rxd    (rxd),
    .bus    (bus)
  );

  always #50 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic stop_v,
                                             input logic par_v);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (NBITS == 11) begin
      f[9]  = par_v;
      f[10] = stop_v;
    end else begin
      f[9] = stop_v;
    end
    return f;
  endfunction

  // Drives one frame starting now; pop/clear are pulsed in the given relative cycle (-1 = never).
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v,
                            input int pop_at, input int clr_at);
    logic [10:0] f;
    f = frame_bits(d, stop_v, par_v);
    for (int t = 0; t < NBITS * DIV; t++) begin
      rxd           = f[t / DIV];
      bus.i_pop     = (t == pop_at);
      bus.i_clr_err = (t == clr_at);
      tick();
    end
    bus.i_pop     = 1'b0;
    bus.i_clr_err = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.i_clr_err = 1'b1;
    tick();
    bus.i_clr_err = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rxd    = 1'b1;
    repeat (5) tick();
    n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.o_valid); else n_pass++;
    n_checks++; if (bus.o_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.o_data); else n_pass++;
    n_checks++; if (bus.o_overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.o_overrun); else n_pass++;
    n_checks++; if (bus.o_frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", bus.o_frame_err); else n_pass++;
    n_checks++; if (bus.o_parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b want 0", bus.o_parity_err); else n_pass++;
    resetn = 1'b1;
    idle(5);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [10:0] f;
    logic [7:0]  e;
    f = frame_bits(8'h55, 1'b1, ^8'h55);
    exp_q.push_back(8'h55);
    for (int t = 0; t < NBITS * DIV; t++) begin
      rxd = f[t / DIV];
      if (t == STOP_CYC) begin
        n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL basic_valid_early: cycle %0d got %b want 0", t, bus.o_valid); else n_pass++;
      end
      if (t == STOP_CYC + 1) begin
        n_checks++; if (bus.o_valid !== 1'b1) $display("FAIL basic_valid_rise: cycle %0d got %b want 1", t, bus.o_valid); else n_pass++;
      end
      tick();
    end
    e = exp_q.pop_front();
    n_checks++; if (bus.o_data !== e) $display("FAIL basic_data: got %h want %h", bus.o_data, e); else n_pass++;
    n_checks++; if ({bus.o_overrun, bus.o_frame_err, bus.o_parity_err} !== 3'b000)
      $display("FAIL basic_flags: got %b want 000", {bus.o_overrun, bus.o_frame_err, bus.o_parity_err}); else n_pass++;
    bus.i_pop = 1'b1;
    tick();
    bus.i_pop = 1'b0;
    n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL basic_pop_valid: got %b want 0", bus.o_valid); else n_pass++;
    $display("test_basic byte %h done", e);
  endtask

  task automatic test_false_start();
    rxd = 1'b0;
    repeat (3) tick();
    idle(4 * DIV);
    n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL false_start_valid: got %b want 0", bus.o_valid); else n_pass++;
    n_checks++; if (bus.o_frame_err !== 1'b0) $display("FAIL false_start_frame_err: got %b want 0", bus.o_frame_err); else n_pass++;
    $display("test_false_start done");
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1, ^8'(b), -1, -1);
      if (b <= 4) exp_q.push_back(8'(b));
    end
    idle(5);
    n_checks++; if (bus.o_overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", bus.o_overrun); else n_pass++;
    n_checks++; if (bus.o_data !== exp_q[0]) $display("FAIL overrun_head: got %h want %h", bus.o_data, exp_q[0]); else n_pass++;
    // Pop lands on the same edge as the push of 0x06 into a full FIFO.
    send_frame(8'h06, 1'b1, ^8'h06, STOP_CYC, -1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h06);
    idle(5);
    n_checks++; if (bus.o_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", bus.o_overrun); else n_pass++;
    pulse_clr();
    n_checks++; if (bus.o_overrun !== 1'b0) $display("FAIL overrun_clr: got %b want 0", bus.o_overrun); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== e)
        $display("FAIL overrun_drain: got valid=%b data=%h want valid=1 data=%h", bus.o_valid, bus.o_data, e); else n_pass++;
      bus.i_pop = 1'b1;
      tick();
      bus.i_pop = 1'b0;
    end
    n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL overrun_empty: got %b want 0", bus.o_valid); else n_pass++;
    $display("test_overrun done");
  endtask

  task automatic test_pop_empty();
    logic [7:0] e;
    send_frame(8'hA3, 1'b1, ^8'hA3, STOP_CYC, -1);
    exp_q.push_back(8'hA3);
    idle(3);
    e = exp_q.pop_front();
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== e)
      $display("FAIL pop_empty: got valid=%b data=%h want valid=1 data=%h", bus.o_valid, bus.o_data, e); else n_pass++;
    bus.i_pop = 1'b1;
    tick();
    bus.i_pop = 1'b0;
    $display("test_pop_empty byte %h done", e);
  endtask

  task automatic test_break();
    logic [7:0] e;
    int         got;
    // Clear is pulsed on the very cycle the bad stop bit is sampled.
    send_frame(8'h3C, 1'b0, ^8'h3C, -1, STOP_CYC);
    rxd = 1'b0;
    repeat (30 * DIV) tick();
    n_checks++; if (bus.o_frame_err !== 1'b1) $display("FAIL break_frame_err: got %b want 1", bus.o_frame_err); else n_pass++;
    n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL break_no_push: got %b want 0", bus.o_valid); else n_pass++;
    idle(20);
    send_frame(8'h7E, 1'b1, ^8'h7E, -1, -1);
    exp_q.push_back(8'h7E);
    idle(5);
    got = 0;
    while (bus.o_valid === 1'b1 && got < 8) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++; if (bus.o_data !== e) $display("FAIL break_data: got %h want %h", bus.o_data, e); else n_pass++;
      end
      got++;
      bus.i_pop = 1'b1;
      tick();
      bus.i_pop = 1'b0;
    end
    n_checks++; if (got !== 1) $display("FAIL break_count: got %0d bytes want 1", got); else n_pass++;
    pulse_clr();
    n_checks++; if (bus.o_frame_err !== 1'b0) $display("FAIL break_clr: got %b want 0", bus.o_frame_err); else n_pass++;
    $display("test_break done");
  endtask

  task automatic test_parity();
    logic [7:0] e;
`ifdef UART_RX_PARITY_EN
    send_frame(8'hA5, 1'b1, 1'b1, -1, -1);
    idle(5);
    n_checks++; if (bus.o_parity_err !== 1'b1) $display("FAIL parity_bad_flag: got %b want 1", bus.o_parity_err); else n_pass++;
    n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL parity_bad_push: got %b want 0", bus.o_valid); else n_pass++;
    pulse_clr();
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
`else
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
`endif
    exp_q.push_back(8'hA5);
    idle(5);
    e = exp_q.pop_front();
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== e)
      $display("FAIL parity_good: got valid=%b data=%h want valid=1 data=%h", bus.o_valid, bus.o_data, e); else n_pass++;
    n_checks++; if (bus.o_parity_err !== 1'b0) $display("FAIL parity_good_flag: got %b want 0", bus.o_parity_err); else n_pass++;
    bus.i_pop = 1'b1;
    tick();
    bus.i_pop = 1'b0;
    $display("test_parity byte %h done", e);
  endtask

  task automatic test_reset_mid();
    logic [10:0] f;
    logic [7:0]  e;
    send_frame(8'h99, 1'b1, ^8'h99, -1, -1);
    exp_q.push_back(8'h99);
    idle(5);
    n_checks++; if (bus.o_valid !== 1'b1) $display("FAIL rstmid_prefill: got %b want 1", bus.o_valid); else n_pass++;
    f = frame_bits(8'hC3, 1'b1, ^8'hC3);
    for (int t = 0; t < 5 * DIV + DIV / 2; t++) begin
      rxd = f[t / DIV];
      tick();
    end
    resetn = 1'b0;
    rxd    = 1'b1;
    repeat (3) tick();
    exp_q.delete();
    n_checks++; if (bus.o_valid !== 1'b0 || bus.o_data !== 8'h00)
      $display("FAIL rstmid_outputs: got valid=%b data=%h want valid=0 data=00", bus.o_valid, bus.o_data); else n_pass++;
    n_checks++; if ({bus.o_overrun, bus.o_frame_err, bus.o_parity_err} !== 3'b000)
      $display("FAIL rstmid_flags: got %b want 000", {bus.o_overrun, bus.o_frame_err, bus.o_parity_err}); else n_pass++;
    resetn = 1'b1;
    idle(10);
    send_frame(8'h12, 1'b1, ^8'h12, -1, -1);
    exp_q.push_back(8'h12);
    idle(5);
    e = exp_q.pop_front();
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== e)
      $display("FAIL rstmid_fresh: got valid=%b data=%h want valid=1 data=%h", bus.o_valid, bus.o_data, e); else n_pass++;
    bus.i_pop = 1'b1;
    tick();
    bus.i_pop = 1'b0;
    n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL rstmid_single: got %b want 0", bus.o_valid); else n_pass++;
    $display("test_reset_mid done");
  endtask

  initial begin
    bus.i_pop     = 1'b0;
    bus.i_clr_err = 1'b0;
    test_reset();
    test_basic();
    test_false_start();
    test_overrun();
    test_pop_empty();
    test_break();
    test_parity();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receiver for the SOC IO page: the receive counterpart of the existing UART emitter. Samples the asynchronous RXD pin, deframes 8N1 characters, and buffers received bytes in a small FIFO. Firmware reads bytes and status through a valid/pop interface on the IO bus. Error flags are sticky and cleared by an explicit pulse.

## Interface
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- BAUD_RATE, 1_000_000, line rate.
- FIFO_DEPTH, 4, receive buffer entries; must be a power of 2 and at least 2.
- clk  in  1  system clock.
- resetn  in  1  reset: synchronous, active-low.
- rxd  in  1  asynchronous serial input; idles high.
- o_data  out  8  head-of-FIFO byte; valid only while o_valid=1.
- o_valid  out  1  FIFO not empty.
- i_pop  in  1  consume the head byte; ignored when o_valid=0.
- i_clr_err  in  1  single-cycle pulse that clears all sticky error flags.
- o_overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- o_frame_err  out  1  sticky; a stop bit was sampled low.
- o_parity_err  out  1  sticky; parity mismatch (see Configuration).

## Operation
- DIV = CLK_FREQ_HZ / BAUD_RATE, rounded down. DIV < 4 is an elaboration error.
- Baud counter width is $clog2(DIV).
- rxd passes through a 2-FF synchronizer. All logic uses the synchronized value rxs.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
  - IDLE: when rxs=0, load the counter with DIV/2-1 and go to START.
  - START: at the counter end, sample rxs. If 1 (false start), go to IDLE. Otherwise reload with DIV-1, clear the bit index, and go to DATA.
  - DATA: every DIV cycles, shift rxs into the shift register LSB first. After bit 7, go to PARITY or STOP.
  - STOP: sample rxs.
    - If 1 and no parity error: push the byte and go to IDLE.
    - If 1 with a parity error: set o_parity_err, discard the byte, and go to IDLE.
    - If 0: set o_frame_err, discard the byte, and go to BREAK.
  - BREAK: stay until rxs=1, then go to IDLE. This prevents a held-low line from producing spurious characters.
- FIFO:
  - Read and write pointers carry one extra wrap bit.
  - Full when the pointers differ only in the MSB.
  - Reads are first-word fall-through: o_data shows the head entry combinationally from registered storage.
- Boundary rules:
  - Push while full and no pop in the same cycle: byte dropped, o_overrun set.
  - Push and pop in the same cycle while full: both accepted, occupancy unchanged, no overrun.
  - Push and pop in the same cycle while empty: pop ignored, push accepted.
  - i_clr_err in the same cycle as a new error event: the set wins and the flag stays 1.
  - Reset mid-character: FSM returns to IDLE, the partial byte is discarded, and the FIFO is emptied.
- Reset values:
  - o_valid=0, o_data=0.
  - All error flags 0.
  - Synchronizer flops reset to 1 (idle level).

## Timing
- Let T be the first cycle in which rxs=0 while in IDLE (2 cycles after the pin edge).
- Sample points:
  - Start bit at T+DIV/2.
  - Data bit k (k=0..7) at T+DIV/2+(k+1)·DIV.
  - Stop bit at T+DIV/2+9·DIV without parity, T+DIV/2+10·DIV with parity.
- The push is registered, so o_valid rises in the cycle after the stop sample.
- A pop asserted in cycle n updates o_data/o_valid in cycle n+1.
- The next start edge is detectable in the cycle after the STOP→IDLE transition, which gives half a bit of margin.

## Configuration
- UART_RX_PARITY_EN
  - Defined: an even-parity bit is expected after bit 7 and sampled in the PARITY state. On mismatch, STOP still checks framing, but the byte is discarded and o_parity_err is set.
  - Undefined: no PARITY state, the frame is 8N1, and o_parity_err is tied to 0.

## Structure
- Shared package uart_pkg:
  - FSM state enum.
  - Function computing DIV and the counter width from CLK_FREQ_HZ and BAUD_RATE.
  - Constant DATA_BITS = 8.
  - The emitter reuses the DIV function from this package.
- One sub-module, uart_rx_fifo:
  - Parameterized by width and depth.
  - Ports: push, pop, data in/out, empty, full.
  - It performs the overrun-drop decision itself and flags drops to the parent.
- Top-level uart_receiver holds the synchronizer, baud counter, FSM, and sticky flags.

## Test plan
Bench settings: CLK_FREQ_HZ=10_000_000, BAUD_RATE=1_000_000 (DIV=10), FIFO_DEPTH=4.
- Send 0x55 8N1 with the pin edge at cycle 0 → o_valid rises at cycle 98, o_data=0x55, no flags set; i_pop → o_valid=0 in the next cycle.
- Pull rxd low for 3 cycles, then return it high → no byte pushed, FSM back in IDLE, o_valid stays 0.
- Send 0x01..0x05 with no pops → FIFO holds 0x01..0x04 and o_overrun=1. Then pop on the same cycle as byte 0x06 completes → 0x06 accepted, o_overrun cleared only after i_clr_err.
- Send 0x3C with the stop bit low, then hold rxd low for 30 bit-times, then release and send 0x7E → o_frame_err=1, exactly one byte 0x7E received.
- With UART_RX_PARITY_EN: send 0xA5 with parity bit 1 (wrong; even parity expects 0) → o_parity_err=1 and no push. Then send 0xA5 with parity bit 0 → byte received.
- Assert resetn=0 at mid bit 4 of 0xC3 → all outputs return to reset values and the FIFO is empty. After resetn returns to 1, a fresh 0x12 is received correctly.
